sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//  Positioned, scaled, animated sprite renderer between VGA timing and the compositor.
//  Maps DrawX/DrawY to an address in an external synchronous sprite ROM holding FRAMES frames.
//  Returns a palette index plus an opaque-hit flag, pipeline-aligned to the pixel.
//  Successor to the full-screen stretch renderer: arbitrary position, power-of-2 scale,
//  frame animation, transparency and tear-free position update.
// PARAMETERS
//  SPR_W       64  sprite width in source pixels (power of 2)
//  SPR_H       64  sprite height in source pixels (power of 2)
//  FRAMES      4   animation frames stored back-to-back in ROM (>=1)
//  IDX_W       4   palette index width
//  TRANSP_IDX  0   index treated as transparent
//  ANIM_DIV    8   video frames per animation step (>=1)
//  ADDR_W      $clog2(SPR_W*SPR_H*FRAMES)  ROM address width (derived)
// PORTS
//  vga_clk     in   1       pixel clock, all state on posedge
//  reset_n     in   1       asynchronous, active-low reset
//  DrawX       in   10      current pixel x
//  DrawY       in   10      current pixel y
//  blank       in   1       1 = active video region
//  frame_start in   1       one-cycle pulse at start of vertical blank
//  pos_x       in   10      sprite top-left x (shadowed)
//  pos_y       in   10      sprite top-left y (shadowed)
//  scale_log2  in   2       scale = 1<<scale_log2 (1,2,4,8) (shadowed)
//  anim_en     in   1       enable automatic frame advance
//  frame_load  in   1       request load of frame_sel at next frame_start
//  frame_sel   in   $clog2(FRAMES)  frame to load
//  rom_addr    out  ADDR_W  registered ROM address
//  rom_q       in   IDX_W   ROM data, valid 1 cycle after rom_addr
//  pix_idx     out  IDX_W   palette index of sprite pixel
//  pix_hit     out  1       1 = opaque sprite pixel at this position
//  cur_frame   out  $clog2(FRAMES)  frame currently displayed
// BEHAVIOUR
//  Reset: rom_addr, pix_idx, pix_hit, cur_frame, shadow regs, anim divider, load flag all 0.
//  Shadowing: pos_x/pos_y/scale_log2 copied to shadow regs only on frame_start;
//   mid-frame input changes never affect the visible frame (no tearing).
//  Stage 1 (edge 1): rel_x = DrawX - sh_x, rel_y = DrawY - sh_y, 11-bit signed.
//   inside = rel_x>=0 && rel_x < (SPR_W<<sh_s) && rel_y>=0 && rel_y < (SPR_H<<sh_s).
//   Comparisons use 11 bits: no wrap, so sprite clips at screen edges.
//   rom_addr <= cur_frame*SPR_W*SPR_H + (rel_y>>sh_s)*SPR_W + (rel_x>>sh_s); shifts, no dividers.
//   Outside: rom_addr holds its value. inside and blank are delayed along the pipe.
//  Stage 2 (edge 2): ROM samples rom_addr; rom_q valid.
//  Stage 3 (edge 3): pix_idx <= rom_q;
//   pix_hit <= inside_d2 && blank_d2 && (rom_q != TRANSP_IDX).
//  Latency: exactly 3 vga_clk cycles from DrawX/DrawY to pix_idx/pix_hit. Compositor delays its own paths to match.
//  Animation, evaluated only on frame_start:
//   - frame_load pending: cur_frame <= frame_sel; divider <= 0; pending cleared.
//     Load beats anim advance.
//   - else if anim_en: divider == ANIM_DIV-1 -> divider <= 0 and cur_frame+1, wrap FRAMES-1 -> 0;
//     else divider+1.
//   - anim_en low: cur_frame and divider hold.
//  frame_load pulse latches a pending flag plus frame_sel. A later pulse before frame_start overwrites.
//  frame_load and frame_start in the same cycle: that frame_sel applies immediately.
//  frame_sel >= FRAMES: clamped to FRAMES-1.
//  Reset mid-frame: outputs 0 immediately (async). Sprite reappears at (0,0), scale 1, frame 0,
//   until the first frame_start after release.
// CONFIGURATION
//  SPRITE_FLIP_EN defined: adds input flip_x (1 bit), shadowed like pos_x.
//   When set, source column = SPR_W-1-(rel_x>>sh_s).
//  SPRITE_FLIP_EN undefined: no flip_x port; column = rel_x>>sh_s.
// TESTING
//  Reset: reset_n=0 mid-line -> pix_hit=0, rom_addr=0, cur_frame=0 within same cycle.
//  Placement: pos=(100,50), scale_log2=0, frame_start; DrawX=100,DrawY=50
//   -> rom_addr=0 after 1 edge; pix_hit=1 after 3 edges (non-transparent ROM).
//   DrawX=99 or 164 -> pix_hit=0.
//  Scale: scale_log2=1, pos=(0,0); DrawX=3,DrawY=5 -> rom_addr=2*64+1=129.
//   DrawX=128 -> pix_hit=0.
//  Clip/transparency: pos_x=600, DrawX=639 -> inside, addr col 39.
//   ROM returns TRANSP_IDX -> pix_hit=0; blank=0 -> pix_hit=0.
//  Tearing: change pos_x mid-frame -> addresses unchanged until next frame_start.
//  Animation: anim_en=1, ANIM_DIV=8 -> cur_frame steps 0,1,2,3,0 every 8 frame_start.
//   frame_load(frame_sel=2) with frame_start same cycle -> cur_frame=2, divider reset.

Source files
------------

// File: rtl/sprite_blitter.sv
// Positioned, power-of-2 scaled, animated sprite renderer feeding a synchronous sprite ROM.
// Optional horizontal mirroring is enabled by defining SPRITE_FLIP_EN (adds the flip_x input).
module sprite_blitter #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ANIM_DIV   = 8,
  parameter int ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES),
  parameter int FSEL_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale_log2,
`ifdef SPRITE_FLIP_EN
  input  logic              flip_x,
`endif
  input  logic              anim_en,
  input  logic              frame_load,
  input  logic [FSEL_W-1:0] frame_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_hit,
  output logic [FSEL_W-1:0] cur_frame
);

  localparam int LW    = $clog2(SPR_W);
  localparam int LH    = $clog2(SPR_H);
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  function automatic logic [FSEL_W-1:0] clamp_sel(input logic [FSEL_W-1:0] s);
    if (int'(s) > FRAMES - 1) return FSEL_W'(FRAMES - 1);
    return s;
  endfunction

  function automatic logic [FSEL_W-1:0] next_frame(input logic [FSEL_W-1:0] f);
    if (f == FSEL_W'(FRAMES - 1)) return '0;
    return f + 1'b1;
  endfunction

  logic [9:0]        sh_x, sh_y;
  logic [1:0]        sh_s;
`ifdef SPRITE_FLIP_EN
  logic              sh_flip;
`endif
  logic [DIV_W-1:0]  div_cnt;
  logic              load_pend;
  logic [FSEL_W-1:0] load_sel;

  // Shadow registers and animation state only move at frame_start so a frame never tears.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_s      <= '0;
`ifdef SPRITE_FLIP_EN
      sh_flip   <= 1'b0;
`endif
      cur_frame <= '0;
      div_cnt   <= '0;
      load_pend <= 1'b0;
      load_sel  <= '0;
    end else if (frame_start) begin
      sh_x <= pos_x;
      sh_y <= pos_y;
      sh_s <= scale_log2;
`ifdef SPRITE_FLIP_EN
      sh_flip <= flip_x;
`endif
      if (frame_load || load_pend) begin
        cur_frame <= clamp_sel(frame_load ? frame_sel : load_sel);
        div_cnt   <= '0;
        load_pend <= 1'b0;
      end else if (anim_en) begin
        if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
          div_cnt   <= '0;
          cur_frame <= next_frame(cur_frame);
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end else if (frame_load) begin
      load_pend <= 1'b1;
      load_sel  <= frame_sel;
    end
  end

  logic signed [10:0] rel_x_p0, rel_y_p0;
  logic [11:0]        lim_x_p0, lim_y_p0;
  logic               inside_p0;
  logic [LW-1:0]      col_p0;
  logic [LH-1:0]      row_p0;

  // Stage 0: position relative to the sprite origin, clipped with 11-bit signed math.
  assign rel_x_p0  = $signed({1'b0, DrawX}) - $signed({1'b0, sh_x});
  assign rel_y_p0  = $signed({1'b0, DrawY}) - $signed({1'b0, sh_y});
  assign lim_x_p0  = 12'(SPR_W) << sh_s;
  assign lim_y_p0  = 12'(SPR_H) << sh_s;
  assign inside_p0 = !rel_x_p0[10] && ({1'b0, rel_x_p0} < lim_x_p0) &&
                     !rel_y_p0[10] && ({1'b0, rel_y_p0} < lim_y_p0);
  assign row_p0    = LH'(rel_y_p0[9:0] >> sh_s);
`ifdef SPRITE_FLIP_EN
  assign col_p0    = sh_flip ? ~LW'(rel_x_p0[9:0] >> sh_s) : LW'(rel_x_p0[9:0] >> sh_s);
`else
  assign col_p0    = LW'(rel_x_p0[9:0] >> sh_s);
`endif

  logic inside_p1, blank_p1, inside_p2, blank_p2;

  // Stage 1: registered ROM address; holds its last value while outside the sprite.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      inside_p1 <= 1'b0;
      blank_p1  <= 1'b0;
    end else begin
      if (inside_p0) rom_addr <= ADDR_W'({cur_frame, row_p0, col_p0});
      inside_p1 <= inside_p0;
      blank_p1  <= blank;
    end
  end

  // Stage 2: the ROM samples rom_addr; flags travel alongside.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      inside_p2 <= 1'b0;
      blank_p2  <= 1'b0;
    end else begin
      inside_p2 <= inside_p1;
      blank_p2  <= blank_p1;
    end
  end

  // Stage 3: palette index and opaque-hit flag aligned to the pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_idx <= '0;
      pix_hit <= 1'b0;
    end else begin
      pix_idx <= rom_q;
      pix_hit <= inside_p2 && blank_p2 && (rom_q != IDX_W'(TRANSP_IDX));
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed pixel vectors with hand-computed ROM addresses.
// The ROM model returns 0 (transparent) when addr%13==5, otherwise (addr%15)+1.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic       blank = 1'b0, frame_start = 1'b0, anim_en = 1'b0, frame_load = 1'b0;
  logic [1:0] scale_log2 = '0, frame_sel = '0;
  logic [13:0] rom_addr;
  logic [3:0] rom_q = '0, pix_idx;
  logic       pix_hit;
  logic [1:0] cur_frame;

  sprite_blitter dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .scale_log2(scale_log2),
    .anim_en(anim_en), .frame_load(frame_load), .frame_sel(frame_sel),
    .rom_addr(rom_addr), .rom_q(rom_q), .pix_idx(pix_idx), .pix_hit(pix_hit),
    .cur_frame(cur_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_f(input logic [13:0] a);
    if (int'(a) % 13 == 5) return 4'd0;
    return 4'((int'(a) % 15) + 1);
  endfunction

  always @(posedge clk) rom_q <= rom_f(rom_addr);

  typedef struct {
    bit chk_addr;
    int addr;
    bit hit;
    bit chk_idx;
    int idx;
    string name;
  } exp_t;

  exp_t aq[$];
  exp_t pq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic drive_vld = 1'b0;
  logic [2:0] vp = '0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) vp <= {vp[1:0], drive_vld};

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (vp[0]) begin
      if (aq.size() == 0) check("addr_queue_empty", 0, 1);
      else begin
        e = aq.pop_front();
        if (e.chk_addr) check({e.name, "_addr"}, int'(rom_addr), e.addr);
      end
    end
    if (vp[2]) begin
      if (pq.size() == 0) check("pix_queue_empty", 0, 1);
      else begin
        e = pq.pop_front();
        check({e.name, "_hit"}, int'(pix_hit), int'(e.hit));
        if (e.chk_idx) check({e.name, "_idx"}, int'(pix_idx), e.idx);
      end
    end
  end

  task automatic vec(input string name, input int x, input int y, input bit b,
                     input bit ca, input int ea, input bit eh, input bit ci, input int ei);
    exp_t e;
    @(posedge clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); blank = b; drive_vld = 1'b1;
    e.chk_addr = ca; e.addr = ea; e.hit = eh; e.chk_idx = ci; e.idx = ei; e.name = name;
    aq.push_back(e);
    pq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_vld = 1'b0;
    end
  endtask

  task automatic pulse_fs(input bit with_load);
    @(posedge clk); #1;
    drive_vld = 1'b0; frame_start = 1'b1; frame_load = with_load;
    @(posedge clk); #1;
    frame_start = 1'b0; frame_load = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y, input int s);
    pos_x = 10'(x); pos_y = 10'(y); scale_log2 = 2'(s);
  endtask

  initial begin
    #3;
    check("reset_addr", int'(rom_addr), 0);
    check("reset_hit", int'(pix_hit), 0);
    check("reset_frame", int'(cur_frame), 0);
    #20 reset_n = 1'b1;
    idle(2);

    set_pos(100, 50, 0);
    pulse_fs(1'b0);
    vec("place_tl",  100, 50,  1, 1, 0,    1, 1, 1);
    vec("place_x99",  99, 50,  1, 0, 0,    0, 0, 0);
    vec("place_x164", 164, 50, 1, 0, 0,    0, 0, 0);
    vec("place_br",  163, 113, 1, 1, 4095, 1, 1, 1);
    vec("place_11",  101, 51,  1, 1, 65,   1, 1, 6);
    idle(1);

    set_pos(0, 0, 1);
    pulse_fs(1'b0);
    vec("scale_3_5",   3,   5,   1, 1, 129,  1, 1, 10);
    vec("scale_x128",  128, 5,   1, 0, 0,    0, 0, 0);
    vec("scale_br",    127, 127, 1, 1, 4095, 1, 1, 1);
    idle(1);

    set_pos(600, 0, 0);
    pulse_fs(1'b0);
    vec("clip_639",    639, 0, 1, 1, 39, 1, 1, 10);
    vec("transp",      605, 0, 1, 1, 5,  0, 1, 0);
    vec("blank_off",   610, 1, 0, 1, 74, 0, 1, 15);
    vec("clip_x599",   599, 0, 1, 0, 0,  0, 0, 0);
    idle(1);

    set_pos(0, 0, 0);
    vec("tear_hold",   639, 0, 1, 1, 39, 1, 1, 10);
    idle(1);
    pulse_fs(1'b0);
    vec("tear_new_out", 639, 0, 1, 0, 0, 0, 0, 0);
    vec("tear_new_in",  1,   0, 1, 1, 1, 1, 1, 2);
    idle(4);

    anim_en = 1'b1;
    for (int step = 1; step <= 4; step++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 7) check($sformatf("anim_pre_%0d", step), int'(cur_frame), (step - 1) % 4);
        pulse_fs(1'b0);
      end
      check($sformatf("anim_step_%0d", step), int'(cur_frame), step % 4);
    end
    for (int k = 0; k < 3; k++) pulse_fs(1'b0);
    frame_sel = 2'd2;
    pulse_fs(1'b1);
    check("load_same_cycle", int'(cur_frame), 2);
    for (int k = 0; k < 7; k++) pulse_fs(1'b0);
    check("load_div_reset", int'(cur_frame), 2);
    pulse_fs(1'b0);
    check("load_div_step", int'(cur_frame), 3);

    anim_en = 1'b0;
    frame_sel = 2'd1;
    @(posedge clk); #1; frame_load = 1'b1;
    @(posedge clk); #1; frame_load = 1'b0; frame_sel = 2'd3;
    idle(2);
    check("pend_wait", int'(cur_frame), 3);
    pulse_fs(1'b0);
    check("pend_apply", int'(cur_frame), 1);
    vec("frame1_addr", 1, 0, 1, 1, 4097, 1, 1, 3);
    idle(1);

    for (int i = 0; i < 20 && (aq.size() != 0 || pq.size() != 0); i++) @(posedge clk);
    #2;
    check("queues_drained", aq.size() + pq.size(), 0);

    @(posedge clk); #1;
    DrawX = 10'd1; DrawY = 10'd0; blank = 1'b1;
    idle(4);
    #2;
    check("pre_reset_hit", int'(pix_hit), 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_hit", int'(pix_hit), 0);
    check("mid_reset_addr", int'(rom_addr), 0);
    check("mid_reset_frame", int'(cur_frame), 0);
    check("mid_reset_idx", int'(pix_idx), 0);
    #10 reset_n = 1'b1;
    idle(1);
    set_pos(300, 300, 3);
    vec("post_reset",  3, 2, 1, 1, 131, 1, 1, 12);
    idle(1);
    for (int i = 0; i < 20 && (aq.size() != 0 || pq.size() != 0); i++) @(posedge clk);
    #2;
    check("final_drain", aq.size() + pq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
